// File: rtl/clk_div_ctrl.sv
// Ratio/enable sequencer for an integer clock divider: handshaked ratio loads, glitch-free gating, lock detect.
// Optional lock watchdog is compiled in when CLK_DIV_CTRL_LOCK_TIMEOUT_EN is defined.
module clk_div_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             I_ref_clk,
  input  logic             I_rst_n,
  input  logic             I_req_valid,
  input  logic [WIDTH-1:0] I_req_ratio,
  output logic             o_req_ready,
  input  logic             I_stop,
  input  logic             I_div_clk,
  output logic             o_clk_en,
  output logic [WIDTH-1:0] o_div_ratio,
  output logic             o_locked,
  output logic             o_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LOW = 2'd1,
    GATE     = 2'd2,
    RUN      = 2'd3
  } state_e;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [WIDTH-1:0] RATIO_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] RATIO_ZERO  = WIDTH'(0);

  state_e           state_q;
  logic [WIDTH-1:0] ratio_q;
  logic             stop_q;
  logic             div_q;
  logic [3:0]       settle_q;
  logic [1:0]       edges_q;
  logic             clk_en_q;
  logic [WIDTH-1:0] div_ratio_q;
  logic             locked_q;
  logic             err_q;

  logic hs_s;
  logic legal_s;
  logic rise_s;

`ifdef CLK_DIV_CTRL_LOCK_TIMEOUT_EN
  localparam logic [WIDTH+1:0] WD_ONE  = (WIDTH+2)'(1);
  localparam logic [WIDTH+1:0] WD_BIAS = (WIDTH+2)'(4);
  logic [WIDTH+1:0] wd_q;
  logic [WIDTH+1:0] wd_limit_s;
  assign wd_limit_s = {1'b0, ratio_q, 1'b0} + WD_BIAS;
`endif

  assign o_req_ready = (state_q == IDLE) | ((state_q == RUN) & ~I_stop);
  assign hs_s        = I_req_valid & o_req_ready;
  assign legal_s     = hs_s & (I_req_ratio != RATIO_ZERO);
  assign rise_s      = I_div_clk & ~div_q;

  assign o_clk_en    = clk_en_q;
  assign o_div_ratio = div_ratio_q;
  assign o_locked    = locked_q;
  assign o_err       = err_q;

  // Sequencer FSM; divider controls and status lag the state by one cycle.
  always_ff @(posedge I_ref_clk) begin
    if (!I_rst_n) begin
      state_q     <= IDLE;
      ratio_q     <= RATIO_ONE;
      stop_q      <= 1'b0;
      div_q       <= 1'b0;
      settle_q    <= 4'd0;
      edges_q     <= 2'd0;
      clk_en_q    <= 1'b0;
      div_ratio_q <= RATIO_ONE;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
`ifdef CLK_DIV_CTRL_LOCK_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      div_q    <= I_div_clk;
      clk_en_q <= (state_q == WAIT_LOW) || (state_q == RUN);
      if (state_q == GATE) begin
        div_ratio_q <= ratio_q;
      end

      case (state_q)
        IDLE: begin
          locked_q <= 1'b0;
          edges_q  <= 2'd0;
          if (legal_s) begin
            state_q  <= GATE;
            settle_q <= 4'd0;
          end
        end
        WAIT_LOW: begin
          // Only drop the enable while the divided clock is low, so no runt high pulse escapes.
          if (!I_div_clk) begin
            state_q  <= stop_q ? IDLE : GATE;
            stop_q   <= 1'b0;
            settle_q <= 4'd0;
          end
        end
        GATE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= RUN;
          end else begin
            settle_q <= settle_q + 4'd1;
          end
        end
        RUN: begin
          if (I_stop) begin
            state_q <= WAIT_LOW;
            stop_q  <= 1'b1;
          end else if (legal_s) begin
            state_q <= WAIT_LOW;
          end
          if (!locked_q) begin
            if (ratio_q == RATIO_ONE) begin
              locked_q <= 1'b1;
            end else if (rise_s) begin
              if (edges_q == 2'd1) begin
                locked_q <= 1'b1;
              end
              edges_q <= edges_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

`ifdef CLK_DIV_CTRL_LOCK_TIMEOUT_EN
      // Watchdog restarts on every divided-clock rise and saturates at its limit.
      if ((state_q == RUN) && !locked_q && (ratio_q != RATIO_ONE)) begin
        if (rise_s) begin
          wd_q <= '0;
        end else if (wd_q != wd_limit_s) begin
          wd_q <= wd_q + WD_ONE;
          if ((wd_q + WD_ONE) == wd_limit_s) begin
            err_q <= 1'b1;
          end
        end
      end else begin
        wd_q <= '0;
      end
`endif

      if (legal_s) begin
        ratio_q  <= I_req_ratio;
        locked_q <= 1'b0;
        edges_q  <= 2'd0;
        err_q    <= 1'b0;
`ifdef CLK_DIV_CTRL_LOCK_TIMEOUT_EN
        wd_q     <= '0;
`endif
      end else if (hs_s) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomised scoreboard bench for clk_div_ctrl against a cycle-level reference model.
module tb_clk_div_ctrl;
  localparam int S = 4;

  typedef enum int {PH_OFF, PH_DRAIN, PH_HOLD, PH_ON} phase_t;
  typedef struct {
    bit en;
    int ratio;
    bit lock;
    bit err;
    bit rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, req_valid, stop, div_clk;
  logic [7:0] req_ratio;
  logic       req_ready, clk_en, locked, err;
  logic [7:0] div_ratio;

  clk_div_ctrl #(.WIDTH(8), .SETTLE_CYCLES(S)) dut (
    .I_ref_clk  (clk),
    .I_rst_n    (rst_n),
    .I_req_valid(req_valid),
    .I_req_ratio(req_ratio),
    .o_req_ready(req_ready),
    .I_stop     (stop),
    .I_div_clk  (div_clk),
    .o_clk_en   (clk_en),
    .o_div_ratio(div_ratio),
    .o_locked   (locked),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // reference model state
  phase_t ph;
  bit m_stop, m_prev_div, m_took;
  int m_cap, m_hold_end, m_rises, m_quiet, cyc;
  bit e_en, e_lock, e_err;
  int e_ratio;
  int div_mode, dcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end else begin
      n_pass++;
    end
  endtask

  function automatic void model_reset();
    ph = PH_OFF; m_stop = 1'b0; m_prev_div = 1'b0; m_took = 1'b0;
    m_cap = 1; m_hold_end = 0; m_rises = 0; m_quiet = 0;
    e_en = 1'b0; e_ratio = 1; e_lock = 1'b0; e_err = 1'b0;
  endfunction

  function automatic void model_step(bit rn, bit v, int r, bit s, bit d);
    phase_t old;
    bit good, rise, lock0;
    cyc++;
    if (!rn) begin
      model_reset();
      return;
    end
    old    = ph;
    lock0  = e_lock;
    m_took = v && ((old == PH_OFF) || (old == PH_ON && !s));
    good   = m_took && (r != 0);
    rise   = d && !m_prev_div;
    m_prev_div = d;
    e_en = (old == PH_DRAIN) || (old == PH_ON);
    if (old == PH_HOLD) e_ratio = m_cap;
    if (old == PH_OFF) begin
      e_lock = 1'b0;
      m_rises = 0;
    end
    if (old == PH_ON && !lock0) begin
      if (m_cap == 1) e_lock = 1'b1;
      else if (rise) begin
        m_rises++;
        if (m_rises == 2) e_lock = 1'b1;
      end
    end
`ifdef CLK_DIV_CTRL_LOCK_TIMEOUT_EN
    if (old == PH_ON && !lock0 && m_cap != 1) begin
      if (rise) m_quiet = 0;
      else if (m_quiet < 2 * m_cap + 4) begin
        m_quiet++;
        if (m_quiet == 2 * m_cap + 4) e_err = 1'b1;
      end
    end else begin
      m_quiet = 0;
    end
`endif
    case (old)
      PH_OFF: if (good) begin ph = PH_HOLD; m_hold_end = cyc + S; end
      PH_DRAIN: if (!d) begin
        ph = m_stop ? PH_OFF : PH_HOLD;
        m_hold_end = cyc + S;
        m_stop = 1'b0;
      end
      PH_HOLD: if (cyc == m_hold_end) ph = PH_ON;
      default: begin
        if (s) begin ph = PH_DRAIN; m_stop = 1'b1; end
        else if (good) ph = PH_DRAIN;
      end
    endcase
    if (good) begin
      m_cap = r; e_lock = 1'b0; m_rises = 0; e_err = 1'b0; m_quiet = 0;
    end else if (m_took) begin
      e_err = 1'b1;
    end
  endfunction

  // Divided-clock source: a simple divider driven by the DUT controls, random bits, or tied levels.
  task automatic next_div();
    int r;
    case (div_mode)
      0: if (clk_en === 1'b1) begin
        r = int'(div_ratio);
        if (r <= 1) div_clk = ~div_clk;
        else begin
          dcnt = (dcnt + 1 >= r) ? 0 : dcnt + 1;
          div_clk = (dcnt < r / 2) ? 1'b1 : 1'b0;
        end
      end
      1: div_clk = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      2: div_clk = 1'b0;
      default: div_clk = 1'b1;
    endcase
  endtask

  task automatic cycle(input bit v, input int r, input bit s, input bit rn);
    exp_t rec;
    req_valid = v; req_ratio = 8'(r); stop = s; rst_n = rn;
    next_div();
    rec.en = e_en; rec.ratio = e_ratio; rec.lock = e_lock; rec.err = e_err;
    rec.rdy = (ph == PH_OFF) || (ph == PH_ON && !s);
    sb.push_back(rec);
    @(posedge clk);
    model_step(rn, v, r, s, div_clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 0, 1'b0, 1'b1);
  endtask

  // Monitor: every cycle the DUT presents its outputs, compare against the oldest expectation.
  initial begin
    exp_t rec;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        rec = sb.pop_front();
        chk("clk_en",    32'(clk_en),    32'(rec.en));
        chk("div_ratio", 32'(div_ratio), 32'(rec.ratio));
        chk("locked",    32'(locked),    32'(rec.lock));
        chk("err",       32'(err),       32'(rec.err));
        chk("req_ready", 32'(req_ready), 32'(rec.rdy));
      end
    end
  end

  initial begin
    bit pend;
    int pr, stop_left;
    rst_n = 1'b0; req_valid = 1'b0; req_ratio = 8'd0; stop = 1'b0; div_clk = 1'b0;
    div_mode = 0; dcnt = 0; cyc = 0; pend = 1'b0; pr = 0; stop_left = 0;
    model_reset();
    @(posedge clk);
    #2;
    repeat (3) cycle(1'b0, 0, 1'b0, 1'b0);

    cycle(1'b1, 4, 1'b0, 1'b1);  idle(30);
    cycle(1'b1, 6, 1'b0, 1'b1);  idle(40);
    cycle(1'b1, 3, 1'b0, 1'b1);  idle(30);
    cycle(1'b1, 0, 1'b0, 1'b1);  idle(5);
    cycle(1'b1, 5, 1'b0, 1'b1);  idle(40);
    repeat (6) cycle(1'b1, 2, 1'b1, 1'b1);
    idle(20);
    cycle(1'b1, 1, 1'b0, 1'b1);  idle(20);
    div_mode = 2;
    cycle(1'b1, 5, 1'b0, 1'b1);  idle(30);
    cycle(1'b1, 7, 1'b0, 1'b1);  idle(2);
    cycle(1'b0, 0, 1'b0, 1'b0);
    div_mode = 0;
    idle(3);

    for (int i = 0; i < 4000; i++) begin
      bit rn;
      if ($urandom_range(0, 199) == 0)
        div_mode = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 3));
      if (stop_left > 0) stop_left--;
      else if ($urandom_range(0, 59) == 0) stop_left = $urandom_range(1, 10);
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1'b1;
        case ($urandom_range(0, 15))
          0, 1:           pr = 0;
          13, 14:         pr = $urandom_range(9, 40);
          15:             pr = $urandom_range(1, 255);
          default:        pr = $urandom_range(1, 8);
        endcase
      end
      rn = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      cycle(pend, pr, (stop_left > 0), rn);
      if (m_took || !rn) pend = 1'b0;
    end
    idle(5);

    #10;
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
